// File: rtl/uart_rx_byte_if.sv
// Receive-side bundle for uart_rx_byte: raw serial line in, decoded byte and strobes out.
// The master modport is the receiver that drives the decoded outputs; slave is the line/consumer side.
interface uart_rx_byte_if;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx_serial,
    output rx_byte,
    output rx_dv,
    output frame_err,
    output busy
  );

  modport slave (
    output rx_serial,
    input  rx_byte,
    input  rx_dv,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver for the ATM console path; optional macro UART_RX_DIGIT_FILTER_EN
// restricts accepted bytes to '0'-'9' and 'q'.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_byte_if.master rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LP_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_BREAK   = 3'd4;
  localparam logic [2:0] ST_CLEANUP = 3'd5;

  logic          r_sync1;
  logic          r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_dv;
  logic          r_frame_err;

  logic          w_rx;
  logic          w_half_done;
  logic          w_bit_done;
  logic          w_accept;

  // Synchronizer idles high so a reset never looks like a start bit by itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_bus.rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx        = r_sync2;
  assign w_half_done = (r_cnt == LP_HALF_LAST);
  assign w_bit_done  = (r_cnt == LP_BIT_LAST);

`ifdef UART_RX_DIGIT_FILTER_EN
  assign w_accept = ((r_shift >= 8'h30) && (r_shift <= 8'h39)) || (r_shift == 8'h71);
`else
  assign w_accept = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_byte      <= 8'h00;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) begin
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_bit_idx <= 3'd0;
              r_state   <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (w_bit_done) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // Rejected bytes still take the CLEANUP path so frame timing is identical.
        ST_STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (w_rx) begin
              if (w_accept) begin
                r_byte <= r_shift;
                r_dv   <= 1'b1;
              end
              r_state <= ST_CLEANUP;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_BREAK: begin
          r_cnt <= '0;
          if (w_rx) begin
            r_state <= ST_IDLE;
          end
        end

        ST_CLEANUP: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_bus.rx_byte   = r_byte;
  assign rx_bus.rx_dv     = r_dv;
  assign rx_bus.frame_err = r_frame_err;
  assign rx_bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed self-checking bench for uart_rx_byte at 16 clocks per bit.
// Expectations for 0x41 depend on whether UART_RX_DIGIT_FILTER_EN is defined.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic clk;
  logic rst;

  uart_rx_byte_if rxIf();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_bus (rxIf)
  );

  int compareCount = 0;
  int mismatchCount = 0;
  int cycleCount = 0;
  int startCycle = 0;
  int lastDvCycle = 0;
  int dvCount = 0;
  int feCount = 0;
  int bothCount = 0;
  int holdViolations = 0;
  logic [7:0] heldByte = 8'h00;
  logic [7:0] dvBytes[$];
  int dv0;
  int fe0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Pulse monitor: counts strobes and watches that rx_byte only moves with rx_dv.
  always @(negedge clk) begin
    if (rxIf.rx_dv === 1'b1) begin
      dvCount     <= dvCount + 1;
      lastDvCycle <= cycleCount;
      dvBytes.push_back(rxIf.rx_byte);
    end
    if (rxIf.frame_err === 1'b1) feCount <= feCount + 1;
    if ((rxIf.rx_dv === 1'b1) && (rxIf.frame_err === 1'b1)) bothCount <= bothCount + 1;
    if (rst !== 1'b1) heldByte <= 8'h00;
    else if (rxIf.rx_dv === 1'b1) heldByte <= rxIf.rx_byte;
    else if (rxIf.rx_byte !== heldByte) holdViolations <= holdViolations + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic holdBit(input logic b);
    rxIf.rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one full frame and returns at a negedge with the line high.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    startCycle = cycleCount;
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(data[i]);
    holdBit(stopBit);
    rxIf.rx_serial = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rxIf.rx_serial = 1'b1;
    idleCycles(3);

    $display("[TB] reset values");
    checkOutput("resetByte", {24'h0, rxIf.rx_byte}, 32'h00);
    checkOutput("resetDv", {31'h0, rxIf.rx_dv}, 32'h0);
    checkOutput("resetFrameErr", {31'h0, rxIf.frame_err}, 32'h0);
    checkOutput("resetBusy", {31'h0, rxIf.busy}, 32'h0);
    rst = 1'b1;
    idleCycles(5);

    $display("[TB] single byte 0x35");
    dv0 = dvCount; fe0 = feCount;
    applyStimulus(8'h35, 1'b1);
    idleCycles(10);
    checkOutput("singleByte", {24'h0, rxIf.rx_byte}, 32'h35);
    checkOutput("singleDvCount", dvCount - dv0, 1);
    checkOutput("singleFeCount", feCount - fe0, 0);
    checkOutput("singleLatency", lastDvCycle - startCycle, 155);
    checkOutput("singleBusyIdle", {31'h0, rxIf.busy}, 32'h0);

    $display("[TB] back-to-back frames");
    dvBytes.delete();
    dv0 = dvCount;
    applyStimulus(8'h31, 1'b1);
    applyStimulus(8'h32, 1'b1);
    applyStimulus(8'h33, 1'b1);
    idleCycles(10);
    checkOutput("b2bDvCount", dvCount - dv0, 3);
    checkOutput("b2bQueueSize", dvBytes.size(), 3);
    if (dvBytes.size() == 3) begin
      checkOutput("b2bByte0", {24'h0, dvBytes[0]}, 32'h31);
      checkOutput("b2bByte1", {24'h0, dvBytes[1]}, 32'h32);
      checkOutput("b2bByte2", {24'h0, dvBytes[2]}, 32'h33);
    end
    checkOutput("b2bFinalByte", {24'h0, rxIf.rx_byte}, 32'h33);

    $display("[TB] 4-cycle glitch");
    dv0 = dvCount; fe0 = feCount;
    rxIf.rx_serial = 1'b0;
    idleCycles(4);
    rxIf.rx_serial = 1'b1;
    checkOutput("glitchBusyHigh", {31'h0, rxIf.busy}, 32'h1);
    idleCycles(7);
    checkOutput("glitchBusyFall", {31'h0, rxIf.busy}, 32'h0);
    idleCycles(20);
    checkOutput("glitchDv", dvCount - dv0, 0);
    checkOutput("glitchFe", feCount - fe0, 0);

    $display("[TB] framing error on 0xA5");
    dv0 = dvCount; fe0 = feCount;
    applyStimulus(8'hA5, 1'b0);
    idleCycles(10);
    checkOutput("ferrCount", feCount - fe0, 1);
    checkOutput("ferrDv", dvCount - dv0, 0);
    checkOutput("ferrByteKept", {24'h0, rxIf.rx_byte}, 32'h33);
    checkOutput("ferrBusyIdle", {31'h0, rxIf.busy}, 32'h0);

    $display("[TB] line held low 40 bit times");
    dv0 = dvCount; fe0 = feCount;
    rxIf.rx_serial = 1'b0;
    idleCycles(40 * CPB);
    checkOutput("breakBusy", {31'h0, rxIf.busy}, 32'h1);
    rxIf.rx_serial = 1'b1;
    idleCycles(20);
    checkOutput("breakFeCount", feCount - fe0, 1);
    checkOutput("breakDv", dvCount - dv0, 0);
    checkOutput("breakBusyIdle", {31'h0, rxIf.busy}, 32'h0);
    applyStimulus(8'h38, 1'b1);
    idleCycles(10);
    checkOutput("afterBreakByte", {24'h0, rxIf.rx_byte}, 32'h38);
    checkOutput("afterBreakDv", dvCount - dv0, 1);

    $display("[TB] reset during data bit 4");
    dv0 = dvCount; fe0 = feCount;
    holdBit(1'b0);
    for (int i = 0; i < 4; i++) holdBit(1'b1);
    rxIf.rx_serial = 1'b0;
    idleCycles(8);
    checkOutput("midFrameBusy", {31'h0, rxIf.busy}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("asyncRstByte", {24'h0, rxIf.rx_byte}, 32'h00);
    checkOutput("asyncRstDv", {31'h0, rxIf.rx_dv}, 32'h0);
    checkOutput("asyncRstFe", {31'h0, rxIf.frame_err}, 32'h0);
    checkOutput("asyncRstBusy", {31'h0, rxIf.busy}, 32'h0);
    rxIf.rx_serial = 1'b1;
    idleCycles(3);
    rst = 1'b1;
    idleCycles(3 * CPB);
    checkOutput("abortDv", dvCount - dv0, 0);
    checkOutput("abortFe", feCount - fe0, 0);
    applyStimulus(8'h37, 1'b1);
    idleCycles(10);
    checkOutput("postRstByte", {24'h0, rxIf.rx_byte}, 32'h37);
    checkOutput("postRstDv", dvCount - dv0, 1);

    $display("[TB] digit filter sequence");
    dv0 = dvCount; fe0 = feCount;
    applyStimulus(8'h41, 1'b1);
    idleCycles(10);
`ifdef UART_RX_DIGIT_FILTER_EN
    checkOutput("filterA_Dv", dvCount - dv0, 0);
    checkOutput("filterA_Byte", {24'h0, rxIf.rx_byte}, 32'h37);
`else
    checkOutput("filterA_Dv", dvCount - dv0, 1);
    checkOutput("filterA_Byte", {24'h0, rxIf.rx_byte}, 32'h41);
`endif
    checkOutput("filterA_Fe", feCount - fe0, 0);
    checkOutput("filterA_Busy", {31'h0, rxIf.busy}, 32'h0);
    dv0 = dvCount;
    applyStimulus(8'h39, 1'b1);
    idleCycles(10);
    checkOutput("filter9_Byte", {24'h0, rxIf.rx_byte}, 32'h39);
    checkOutput("filter9_Dv", dvCount - dv0, 1);
    applyStimulus(8'h71, 1'b1);
    idleCycles(10);
    checkOutput("filterQ_Byte", {24'h0, rxIf.rx_byte}, 32'h71);
    checkOutput("filterQ_Dv", dvCount - dv0, 2);
    checkOutput("filterQ_Fe", feCount - fe0, 0);

    checkOutput("dvFeExclusive", bothCount, 0);
    checkOutput("byteHeldBetweenPulses", holdViolations, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial receive front end of the ATM console path. Oversamples the asynchronous UART line, recovers 8N1 frames and presents each received byte with a single-cycle valid strobe. `rx_byte` feeds the ASCII-to-binary input FSM's data input, and `rx_dv` feeds its `status_code_in`. `rx_byte` holds its value between frames because the downstream stage compares it against `'q'` (0x71) on every cycle.

## Interface
- `CLKS_PER_BIT`, default 868 — clock cycles per bit. The default gives 115200 baud at 100 MHz. Legal values are 4 or more.
- `clk` input 1 — system clock; all logic is on the rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `rx_serial` input 1 — raw UART line; idles high; asynchronous to `clk`.
- `rx_byte` output 8 — last accepted byte; held until the next accepted byte.
- `rx_dv` output 1 — one-cycle pulse when `rx_byte` is updated.
- `frame_err` output 1 — one-cycle pulse when the stop bit is sampled low.
- `busy` output 1 — high in every state except IDLE.

## Operation
- `rx_serial` passes through a 2-flop synchronizer before any use. Both flops reset to 1.
- Bit counter is `$clog2(CLKS_PER_BIT)` bits wide. Bit index is 3 bits. Shift register is 8 bits, filled LSB first.
- State machine:
  - **IDLE**: clear the counter. A synchronized low moves to START.
  - **START**: count to `CLKS_PER_BIT/2 - 1` (integer division), then sample.
    - Sample low: clear the counter and bit index, go to DATA.
    - Sample high: glitch; return to IDLE with no output pulses.
  - **DATA**: count to `CLKS_PER_BIT - 1`, then sample into `shift[bit_idx]`.
    - After bit index 7, go to STOP; otherwise increment the index.
  - **STOP**: count to `CLKS_PER_BIT - 1`, then sample.
    - Sample high: load `rx_byte` from the shift register, pulse `rx_dv`, go to CLEANUP.
    - Sample low: pulse `frame_err`, leave `rx_byte` unchanged, go to BREAK.
  - **BREAK**: wait for a synchronized high, then go to IDLE. This prevents a held-low line from being decoded as a 0x00 stream.
  - **CLEANUP**: one cycle, then go to IDLE.
- At most one of `rx_dv` and `frame_err` is high in any cycle.
- Reset values: `rx_byte` = 0x00; `rx_dv`, `frame_err`, `busy` = 0; state = IDLE; counter, bit index and shift register = 0.
- Reset asserted mid-frame aborts immediately. The partial frame produces no pulse. After release, the block waits for a fresh falling edge; a line already low at release is treated as a start.

## Timing
- Synchronizer latency: 2 cycles.
- Start-bit check: `CLKS_PER_BIT/2` cycles after START entry.
- Each data and stop sample: `CLKS_PER_BIT` cycles after the previous sample, i.e. at the bit centre.
- `rx_dv` is registered and asserts in the cycle after the stop-bit sample. `rx_byte` is valid in that same cycle and stays stable until the next `rx_dv`.
- Back-to-back frames are accepted: CLEANUP plus IDLE take 2 cycles, well inside the second half of the stop bit.

## Configuration
- Macro `UART_RX_DIGIT_FILTER_EN`.
- **Defined**:
  - A good frame is accepted only if the byte is 0x30–0x39 (`'0'`–`'9'`) or 0x71 (`'q'`).
  - Any other byte leaves `rx_byte` unchanged, raises no `rx_dv` and no `frame_err`, and the FSM still passes through CLEANUP.
  - Purpose: the downstream digit decoder never sees undefined codes.
- **Undefined**: every good frame updates `rx_byte` and pulses `rx_dv`.

## Test plan
- **Single byte.** `CLKS_PER_BIT`=16; send 0x35 (`'5'`). Expect `rx_byte`=0x35 and exactly one `rx_dv` pulse, 2 cycles plus about 9.5 bit times after the falling edge. `frame_err` stays 0.
- **Back-to-back frames.** Send `'1'`,`'2'`,`'3'` with no idle gap. Expect three `rx_dv` pulses with `rx_byte` = 0x31, 0x32, 0x33, each held until the next pulse.
- **Glitch and framing errors.**
  - Low pulse of 4 cycles: no pulse, returns to IDLE, `busy` falls within 8+2 cycles.
  - Frame 0xA5 with stop bit low: `frame_err` pulses once and `rx_byte` keeps its prior value.
  - Line held low for 40 bit times: exactly one `frame_err`, then a normal frame decodes correctly.
- **Reset mid-frame.** Pull `rst` low during DATA bit 4, then send `'7'` after release. Expect all outputs to return to 0 asynchronously, no pulse for the aborted frame, and `rx_byte`=0x37 with one `rx_dv`.
- **Filter enabled.** With `UART_RX_DIGIT_FILTER_EN` defined, send `'A'`(0x41), `'9'`, `'q'`. Expect no pulse for 0x41, then `rx_byte` = 0x39 and then 0x71, each with one `rx_dv`. With the macro undefined, 0x41 also pulses.
